// File: rtl/stack_exec_ctrl.sv
`default_nettype none
// stack_exec_ctrl: fetch/execute sequencer for a 16-bit stack-machine ISA with an
// internal operand stack, local-variable RAM port and a shared MUL/DIV ALU handshake.
module stack_exec_ctrl #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 12,
    parameter int LV_AW     = 6,
    parameter int STK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              lv_we,
    output logic [LV_AW-1:0]  lv_addr,
    output logic [DATA_W-1:0] lv_wdata,
    input  logic [DATA_W-1:0] lv_rdata,
    output logic              alu_req,
    output logic              alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_ack,
    input  logic [DATA_W-1:0] alu_res
);
    localparam int SP_AW = $clog2(STK_DEPTH);
    localparam int SP_W  = SP_AW + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STK_DEPTH);

    localparam logic [3:0] OP_PUSH = 4'd0,  OP_LOAD = 4'd1,  OP_STORE = 4'd2, OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4,  OP_MUL  = 4'd5,  OP_DIV   = 4'd6, OP_EQ  = 4'd7;
    localparam logic [3:0] OP_NE   = 4'd8,  OP_GT   = 4'd9,  OP_GE    = 4'd10, OP_JMP = 4'd11;
    localparam logic [3:0] OP_JZ   = 4'd12, OP_POP  = 4'd13, OP_RET   = 4'd14;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, LWAIT, AWAIT} state_t;

    state_t              state, state_n;
    logic [PC_W-1:0]     pc, pc_n;
    logic [15:0]         ir, ir_n;
    logic [SP_W-1:0]     sp, sp_n;
    logic [DATA_W-1:0]   result_n, alu_a_n, alu_b_n;
    logic [1:0]          err_code_n;
    logic                done_n, err_n, alu_op_n;

    logic [DATA_W-1:0]   stk [STK_DEPTH];
    logic                stk_we;
    logic [SP_AW-1:0]    stk_widx;
    logic [DATA_W-1:0]   stk_wdata;

    logic [3:0]          opcode;
    logic [11:0]         imm;
    logic [DATA_W-1:0]   imm_sx, top, nxt, bin_res;
    logic [SP_AW-1:0]    top_idx, nxt_idx;
    logic [1:0]          need;
    logic                pushes;

    assign opcode    = ir[15:12];
    assign imm       = ir[11:0];
    assign imm_sx    = {{(DATA_W-12){imm[11]}}, imm};
    assign top_idx   = sp[SP_AW-1:0] - SP_AW'(1);
    assign nxt_idx   = sp[SP_AW-1:0] - SP_AW'(2);
    assign top       = stk[top_idx];
    assign nxt       = stk[nxt_idx];
    assign busy      = (state != IDLE);
    assign imem_addr = pc;
    assign lv_addr   = ir[LV_AW-1:0];
    assign alu_req   = (state == AWAIT);

    // Operand demand and push behaviour per opcode, used for fault checks.
    always_comb begin
        need    = 2'd0;
        pushes  = 1'b0;
        bin_res = '0;
        unique case (opcode)
            OP_PUSH, OP_LOAD:           pushes = 1'b1;
            OP_STORE, OP_JZ, OP_POP, OP_RET: need = 2'd1;
            OP_JMP, 4'd15:              need = 2'd0;
            default:                    need = 2'd2;
        endcase
        unique case (opcode)
            OP_ADD:  bin_res = nxt + top;
            OP_SUB:  bin_res = nxt - top;
            OP_EQ:   bin_res = {{(DATA_W-1){1'b0}}, (nxt == top)};
            OP_NE:   bin_res = {{(DATA_W-1){1'b0}}, (nxt != top)};
            OP_GT:   bin_res = {{(DATA_W-1){1'b0}}, ($signed(nxt) > $signed(top))};
            OP_GE:   bin_res = {{(DATA_W-1){1'b0}}, ($signed(nxt) >= $signed(top))};
            default: bin_res = '0;
        endcase
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        sp_n       = sp;
        result_n   = result;
        err_code_n = err_code;
        done_n     = 1'b0;
        err_n      = 1'b0;
        alu_op_n   = alu_op;
        alu_a_n    = alu_a;
        alu_b_n    = alu_b;
        stk_we     = 1'b0;
        stk_widx   = sp[SP_AW-1:0];
        stk_wdata  = imm_sx;
        imem_req   = 1'b0;
        lv_we      = 1'b0;
        lv_wdata   = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    pc_n       = start_pc;
                    sp_n       = '0;
                    err_code_n = 2'd0;
                    state_n    = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_n    = imem_rdata;
                    pc_n    = pc + PC_W'(1);
                    state_n = EXEC;
                end
            end
            EXEC: begin
                state_n = FETCH;
                if ({{(SP_W-2){1'b0}}, need} > sp) begin
                    err_n = 1'b1; err_code_n = 2'd1; state_n = IDLE;
                end else if (pushes && (sp == SP_FULL)) begin
                    err_n = 1'b1; err_code_n = 2'd2; state_n = IDLE;
                end else if ((opcode == OP_DIV) && (top == '0)) begin
                    err_n = 1'b1; err_code_n = 2'd3; state_n = IDLE;
                end else begin
                    unique case (opcode)
                        OP_PUSH: begin
                            stk_we = 1'b1;
                            sp_n   = sp + SP_W'(1);
                        end
                        OP_LOAD:  state_n = LWAIT;
                        OP_STORE: begin
                            lv_we    = 1'b1;
                            lv_wdata = top;
                        end
                        OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_GT, OP_GE: begin
                            stk_we    = 1'b1;
                            stk_widx  = nxt_idx;
                            stk_wdata = bin_res;
                            sp_n      = sp - SP_W'(1);
                        end
                        OP_MUL, OP_DIV: begin
                            // Operands leave the stack now; the result is pushed on ack.
                            alu_op_n = (opcode == OP_DIV);
                            alu_a_n  = nxt;
                            alu_b_n  = top;
                            sp_n     = sp - SP_W'(2);
                            state_n  = AWAIT;
                        end
                        OP_JMP: pc_n = PC_W'(imm);
                        OP_JZ: begin
                            sp_n = sp - SP_W'(1);
                            if (top == '0) pc_n = PC_W'(imm);
                        end
                        OP_POP: sp_n = sp - SP_W'(1);
                        OP_RET: begin
                            result_n = top;
                            done_n   = 1'b1;
                            sp_n     = sp - SP_W'(1);
                            state_n  = IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            LWAIT: begin
                stk_we    = 1'b1;
                stk_wdata = lv_rdata;
                sp_n      = sp + SP_W'(1);
                state_n   = FETCH;
            end
            AWAIT: begin
                if (alu_ack) begin
                    stk_we    = 1'b1;
                    stk_wdata = alu_res;
                    sp_n      = sp + SP_W'(1);
                    state_n   = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            sp       <= '0;
            result   <= '0;
            err_code <= 2'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            alu_op   <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            sp       <= sp_n;
            result   <= result_n;
            err_code <= err_code_n;
            done     <= done_n;
            err      <= err_n;
            alu_op   <= alu_op_n;
            alu_a    <= alu_a_n;
            alu_b    <= alu_b_n;
        end
    end

    always_ff @(posedge clk) begin
        if (stk_we) stk[stk_widx] <= stk_wdata;
    end
endmodule
`default_nettype wire

// File: doc/stack_exec_ctrl.md
Name: stack_exec_ctrl

Overview:
- Sequencer for the stack-machine datapath that runs code lowered from the compiler's AST node kinds: num, lvar, assign, arithmetic, compare, if/for jumps and return.
- Fetches 16-bit instructions and keeps an internal operand stack.
- Reads and writes the local-variable RAM (one slot per lvar, 8-byte offset / 8).
- Hands MUL/DIV to a shared multicycle ALU through a req/ack handshake and reports the RET value.

Parameters:
- DATA_W, 32, operand and stack word width
- PC_W, 12, instruction address width
- LV_AW, 6, local-variable slot address width
- STK_DEPTH, 16, operand stack entries (power of 2, at least 4)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin execution at start_pc
- start_pc  in  PC_W  entry address
- busy  out  1  high from the cycle after start until done or err
- done  out  1  one-cycle pulse when RET completes
- result  out  DATA_W  RET value; held until the next start
- err  out  1  one-cycle pulse on fault
- err_code  out  2  1 = underflow, 2 = overflow, 3 = divide by zero; held until the next start
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address
- imem_ack  in  1  fetch done; imem_rdata is valid in this cycle
- imem_rdata  in  16  instruction: [15:12] opcode, [11:0] imm
- lv_we  out  1  local RAM write enable
- lv_addr  out  LV_AW  slot = imm[LV_AW-1:0]
- lv_wdata  out  DATA_W  write data
- lv_rdata  in  DATA_W  synchronous read, 1-cycle latency
- alu_req  out  1  MUL/DIV request
- alu_op  out  1  0 = MUL, 1 = DIV
- alu_a  out  DATA_W  left operand
- alu_b  out  DATA_W  right operand
- alu_ack  in  1  alu_res is valid in this cycle
- alu_res  in  DATA_W  ALU result

Behaviour:
- Reset values: all outputs 0. State IDLE, sp = 0, pc = 0.
- Reset is asynchronous at any time. Outstanding imem_req/alu_req drop immediately. Acks arriving in IDLE are ignored.
- States: IDLE, FETCH, EXEC, LWAIT, AWAIT.
  - IDLE: on start, pc = start_pc, sp = 0, err_code = 0 -> FETCH. start is ignored in any other state.
  - FETCH: imem_req = 1, imem_addr = pc. Held until imem_ack (an ack in the same cycle is legal). Latch rdata, pc = pc + 1 mod 2^PC_W -> EXEC.
  - EXEC: one cycle per instruction, then -> FETCH unless noted below.
- Operand rule: b = pop (top), a = pop (next). The result of a op b is pushed.
- Opcodes:
  - 0 PUSH: push sign-extended imm.
  - 1 LOAD: lv_addr = slot -> LWAIT. LWAIT pushes lv_rdata -> FETCH.
  - 2 STORE: lv_we = 1 with top of stack; the value stays on the stack (assign yields its value).
  - 3 ADD and 4 SUB: wrap mod 2^DATA_W.
  - 5 MUL and 6 DIV: alu_req = 1 with stable op/a/b -> AWAIT. Held until alu_ack; push alu_res in the ack cycle -> FETCH.
  - 7 EQ, 8 NE, 9 GT (a>b), 10 GE (a>=b): signed compare; push 1 or 0.
  - 11 JMP: pc = imm[PC_W-1:0].
  - 12 JZ: pop; if zero, pc = imm.
  - 13 POP: discard top.
  - 14 RET: pop into result, done = 1 -> IDLE.
  - 15 NOP: no action.
- Faults are checked in EXEC before any side effect. On a fault: err = 1, err_code set, no stack/RAM/ALU action -> IDLE.
  - Underflow: the opcode needs more operands than sp.
  - Overflow: a push when sp = STK_DEPTH. A binary op nets -1 and never overflows.
  - DIV with b = 0 -> code 3; alu_req is never asserted.
- Stack is full at sp = STK_DEPTH and empty at sp = 0. A push at sp = STK_DEPTH-1 is legal.
- busy = 0 in IDLE, including the cycle done/err pulses.

Test Plan:
- "return 3+4*2;": PUSH 3, PUSH 4, PUSH 2, MUL, ADD, RET. Ack ALU after 3 cycles with 8 -> exactly one alu_req, with a=4, b=2, op=0; done with result=11; sp ends at 0.
- "a=5; return a-7;": PUSH 5, STORE 0, POP, LOAD 0, PUSH 7, SUB, RET -> lv_we at slot 0 with data 5; result=0xFFFFFFFE.
- for-loop "i=0; for(;i<3;i=i+1);": uses JZ/JMP and compare, stalled with 2-cycle imem_ack latency -> 3 iterations, final slot value 3, ends in RET; every imem_addr is correct.
- PUSH 1, PUSH 0, DIV -> err with err_code=3, no alu_req, busy low the next cycle.
- STK_DEPTH+1 PUSHes -> overflow (code 2) on the last one; a lone ADD at sp=1 -> underflow (code 1).
- rst_n low while in AWAIT -> alu_req drops the same cycle; a later alu_ack is ignored; a new start runs cleanly.
